// File: rtl/trace_pkg.sv
// Shared types for the trace recorder: capture FSM states and pointer-width helper.
package trace_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StArmed,
    StPost,
    StDump
  } trace_state_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/trace_recorder_if.sv
// Valid/ready read port carrying the captured window out of the trace recorder.
interface trace_recorder_if #(
  parameter int unsigned WIDTH = 6
);

  logic             rd_valid_o;
  logic             rd_ready_i;
  logic [WIDTH-1:0] rd_data_o;
  logic             rd_last_o;

  modport master (
    output rd_valid_o,
    output rd_data_o,
    output rd_last_o,
    input  rd_ready_i
  );

  modport slave (
    input  rd_valid_o,
    input  rd_data_o,
    input  rd_last_o,
    output rd_ready_i
  );

endinterface

// File: rtl/trace_mem.sv
// DEPTH x WIDTH trace storage: one synchronous write port, one asynchronous read port, no reset.
module trace_mem
  import trace_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AddrW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/trace_recorder.sv
// Trigger-based capture of a monitored signal into a circular buffer, dumped oldest-first.
// Define TRACE_RECORDER_FORMAL_EN to compile in formal properties (under FORMAL).
module trace_recorder
  import trace_pkg::*;
#(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned PRE_TRIG = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             arm_i,
  input  logic             trig_i,
  trace_recorder_if.master rd,
  output logic             busy_o
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int          PostN = int'(DEPTH) - int'(PRE_TRIG) - 1;
  localparam logic [CntW-1:0] PreLast  = CntW'(PRE_TRIG - 1);
  localparam logic [CntW-1:0] PostLast = CntW'((PostN > 0) ? PostN - 1 : 0);
  localparam logic [CntW-1:0] BeatLast = CntW'(DEPTH - 1);

  trace_state_e    state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we;
  logic [WIDTH-1:0] rdata;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arm_i) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
          state_d  = StPre;
        end
      end
      StPre: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == PreLast) begin
          cnt_d   = '0;
          state_d = StArmed;
        end
      end
      StArmed: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (trig_i) begin
          cnt_d = '0;
          // With PRE_TRIG = DEPTH-1 there are no post-trigger writes at all.
          if (PostN == 0) begin
            rd_ptr_d = wr_ptr_q + 1'b1;
            state_d  = StDump;
          end else begin
            state_d = StPost;
          end
        end
      end
      StPost: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == PostLast) begin
          cnt_d    = '0;
          rd_ptr_d = wr_ptr_q + 1'b1;
          state_d  = StDump;
        end
      end
      StDump: begin
        if (rd.rd_ready_i) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == BeatLast) begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  trace_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr_q),
    .wdata(sample_i),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );

  // Data is gated so the undefined memory never leaks out while idle or in reset.
  assign rd.rd_valid_o = (state_q == StDump);
  assign rd.rd_data_o  = rd.rd_valid_o ? rdata : '0;
  assign rd.rd_last_o  = rd.rd_valid_o && (cnt_q == BeatLast);
  assign busy_o        = (state_q != StIdle);

`ifdef TRACE_RECORDER_FORMAL_EN
`ifdef FORMAL
  a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
    state_q inside {StIdle, StPre, StArmed, StPost, StDump});
  a_valid_in_dump: assert property (@(posedge clk) disable iff (!rst_n)
    rd.rd_valid_o |-> state_q == StDump);
  a_read_stable: assert property (@(posedge clk) disable iff (!rst_n)
    rd.rd_valid_o && !rd.rd_ready_i |=> $stable(rd.rd_data_o) && $stable(rd.rd_last_o));
  a_no_write_in_dump: assert property (@(posedge clk) disable iff (!rst_n)
    state_q == StDump |-> !we);
  c_full_sequence: cover property (@(posedge clk) disable iff (!rst_n)
    state_q == StIdle && arm_i ##1 (state_q != StIdle) [*1:$] ##1 state_q == StIdle);
  c_first_armed_trig: cover property (@(posedge clk) disable iff (!rst_n)
    state_q == StPre ##1 (state_q == StArmed && trig_i));
`endif
`endif

endmodule

// File: tb/tb_trace_recorder.sv
// Directed-plus-random bench for trace_recorder; expected dumps come from a per-cycle sample history.
module tb_trace_recorder;

  localparam int W = 6;
  localparam int D = 8;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sample_i = '0;
  logic         arm_i = 1'b0;
  logic         trig_i = 1'b0;
  logic         busy_o;

  trace_recorder_if #(.WIDTH(W)) rd_if ();

  trace_recorder #(
    .WIDTH   (W),
    .DEPTH   (D),
    .PRE_TRIG(P)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sample_i(sample_i),
    .arm_i   (arm_i),
    .trig_i  (trig_i),
    .rd      (rd_if),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit rnd_mode = 1'b0;
  logic [W-1:0] hist [0:8191];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge: record what the DUT saw, then drive the next sample away from the edge.
  task automatic tick();
    @(posedge clk);
    hist[cyc & 8191] = sample_i;
    cyc++;
    #1;
    sample_i = rnd_mode ? W'($urandom) : W'(cyc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", rd_if.rd_valid_o, 0);
    check("rst_last", rd_if.rd_last_o, 0);
    check("rst_data", rd_if.rd_data_o, 0);
    check("rst_busy", busy_o, 0);
    tick();
    rst_n = 1'b1;
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0,..., 2 random.
  task automatic capture(input int armed_wait, input bit trig_hold, input bit rearm,
                         input int ready_mode, input int abort_post, input int abort_beat);
    logic [W-1:0] exp_q [$];
    int           t;
    int           beats;
    int           cycles;
    bit           stalled;
    bit           rdy;
    logic [W-1:0] held_data;
    logic         held_last;

    check("idle_before_arm", busy_o, 0);
    arm_i  = 1'b1;
    trig_i = trig_hold;
    tick();
    arm_i = 1'b0;
    for (int i = 0; i < P; i++) begin
      check("busy_pre", busy_o, 1);
      check("valid_pre", rd_if.rd_valid_o, 0);
      tick();
    end
    for (int i = 0; i < armed_wait; i++) begin
      trig_i = 1'b0;
      tick();
    end
    trig_i = 1'b1;
    t = cyc;
    tick();
    trig_i = 1'b0;
    for (int i = 0; i < D - P - 1; i++) begin
      check("valid_post", rd_if.rd_valid_o, 0);
      if (abort_post == i) begin
        do_reset();
        return;
      end
      if (rearm && i == 0) arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
    end
    check("valid_latency", rd_if.rd_valid_o, 1);

    // The window is the PRE_TRIG samples before the trigger, the trigger, and the rest after it.
    for (int i = 0; i < D; i++) exp_q.push_back(hist[(t - P + i) & 8191]);

    beats   = 0;
    cycles  = 0;
    stalled = 1'b0;
    while (beats < D && cycles < 64) begin
      rdy = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (cycles % 3 == 0) : 1'($urandom);
      rd_if.rd_ready_i = rdy;
      if (beats == abort_beat) begin
        do_reset();
        rd_if.rd_ready_i = 1'b0;
        return;
      end
      check("valid_dump", rd_if.rd_valid_o, 1);
      if (stalled) begin
        check("data_stable", rd_if.rd_data_o, held_data);
        check("last_stable", rd_if.rd_last_o, held_last);
      end
      if (rdy) begin
        check($sformatf("beat%0d_data", beats), rd_if.rd_data_o, exp_q[beats]);
        check($sformatf("beat%0d_last", beats), rd_if.rd_last_o, (beats == D - 1));
        beats++;
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        held_data = rd_if.rd_data_o;
        held_last = rd_if.rd_last_o;
      end
      tick();
      cycles++;
    end
    rd_if.rd_ready_i = 1'b0;
    check("beat_count", beats, D);
    if (ready_mode == 0) check("no_bubbles", cycles, D);
    check("busy_after", busy_o, 0);
    check("valid_after", rd_if.rd_valid_o, 0);
    tick();
    check("still_idle", busy_o, 0);
  endtask

  initial begin
    rd_if.rd_ready_i = 1'b0;
    tick();
    tick();
    check("reset_valid", rd_if.rd_valid_o, 0);
    check("reset_last", rd_if.rd_last_o, 0);
    check("reset_data", rd_if.rd_data_o, 0);
    check("reset_busy", busy_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    capture(3, 1'b0, 1'b0, 0, -1, -1);   // basic
    capture(0, 1'b0, 1'b0, 0, -1, -1);   // earliest trigger
    capture(0, 1'b1, 1'b1, 0, -1, -1);   // trig held through PRE, re-arm in POST
    capture(2, 1'b0, 1'b0, 1, -1, -1);   // backpressure
    capture(1, 1'b0, 1'b0, 0, 1, -1);    // reset during POST
    capture(1, 1'b0, 1'b0, 0, -1, 3);    // reset during beat 3
    capture(0, 1'b0, 1'b0, 0, -1, -1);   // recovery
    capture(20, 1'b0, 1'b0, 0, -1, -1);  // wrap-around

    rnd_mode = 1'b1;
    for (int n = 0; n < 8; n++) begin
      capture(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 2, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
